// File: rtl/ceyloniac_alu_mc.sv
// ceyloniac_alu_mc: multi-cycle ALU between operand fetch and writeback.
// Single-cycle ops register their result one edge after accept. MUL is an
// iterative LSB-first shift-add that takes ALU_DATA_WIDTH+1 cycles.
// Build option: define ALU_MUL_EN to include the iterative multiplier. Without
// it, op 0010 completes in one cycle with result 0 and Z=V=1.
module ceyloniac_alu_mc #(
  parameter int ALU_DATA_WIDTH = 32,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int ALU_SH_WIDTH   = $clog2(ALU_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_in_valid,
  output logic                      alu_in_ready,
  input  logic [ALU_DATA_WIDTH-1:0] alu_in_a,
  input  logic [ALU_DATA_WIDTH-1:0] alu_in_b,
  input  logic [ALU_OP_WIDTH-1:0]   alu_sel,
  output logic                      alu_out_valid,
  input  logic                      alu_out_ready,
  output logic [ALU_DATA_WIDTH-1:0] alu_out,
  output logic [3:0]                alu_status
);

  localparam int W  = ALU_DATA_WIDTH;
  localparam int SH = ALU_SH_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_EQZ  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;
  localparam logic [3:0] OP_EXT  = 4'b1110;
  localparam logic [3:0] OP_PASB = 4'b1111;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(ALU_DATA_WIDTH);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

  state_e state_q, state_d, start_state;
  logic   accept;
  logic   is_mul;

  logic [W-1:0] out_q, out_d;
  logic [3:0]   status_q, status_d;

  // Opcode decode; any set bit above the low nibble marks an undefined op
  logic [3:0] op4;
  logic       undef_op;
  assign op4 = alu_sel[3:0];

  generate
    if (ALU_OP_WIDTH > 4) begin : g_wide_sel
      assign undef_op = |alu_sel[ALU_OP_WIDTH-1:4];
    end else begin : g_narrow_sel
      assign undef_op = 1'b0;
    end
  endgenerate

  // Single-cycle datapath operands
  logic [SH-1:0]       sh_amt, ex_pos, ex_len;
  logic [W-1:0]        addend, subtr, ex_mask, asr_res;
  logic [W:0]          add_w, sub_w;
  logic signed [W-1:0] a_sgn;

  assign sh_amt  = alu_in_b[SH-1:0];
  assign ex_pos  = alu_in_b[SH-1:0];
  assign ex_len  = alu_in_b[2*SH-1:SH];
  assign addend  = (op4 == OP_INC) ? W'(1) : alu_in_b;
  assign subtr   = (op4 == OP_DEC) ? W'(1) : alu_in_b;
  assign add_w   = {1'b0, alu_in_a} + {1'b0, addend};
  assign sub_w   = {1'b0, alu_in_a} - {1'b0, subtr};
  assign a_sgn   = alu_in_a;
  assign asr_res = a_sgn >>> sh_amt;
  // A zero length field selects the whole word
  assign ex_mask = (ex_len == '0) ? '1 : ((W'(1) << ex_len) - W'(1));

  logic [W-1:0] res_c;
  logic         c_c, v_c, z_c, n_c;

  // Combinational result and carry/overflow for every single-cycle op
  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op4)
      OP_ADD, OP_INC: begin
        res_c = add_w[W-1:0];
        c_c   = add_w[W];
        v_c   = (alu_in_a[W-1] == addend[W-1]) && (add_w[W-1] != alu_in_a[W-1]);
      end
      OP_SUB, OP_DEC: begin
        res_c = sub_w[W-1:0];
        c_c   = sub_w[W];
        v_c   = (alu_in_a[W-1] != subtr[W-1]) && (sub_w[W-1] != alu_in_a[W-1]);
      end
`ifndef ALU_MUL_EN
      OP_MUL: begin
        res_c = '0;
        v_c   = 1'b1;
      end
`endif
      OP_PASS, OP_PASB: res_c = alu_in_a;
      OP_SHL:           res_c = alu_in_a << sh_amt;
      OP_SHR:           res_c = alu_in_a >> sh_amt;
      OP_ASR:           res_c = asr_res;
      OP_AND:           res_c = alu_in_a & alu_in_b;
      OP_OR:            res_c = alu_in_a | alu_in_b;
      OP_XOR:           res_c = alu_in_a ^ alu_in_b;
      OP_NOT:           res_c = ~alu_in_a;
      OP_EQZ:           res_c = (alu_in_a == '0) ? W'(1) : '0;
      OP_EXT:           res_c = (alu_in_a >> ex_pos) & ex_mask;
      default:          res_c = '0;
    endcase
    if (undef_op) begin
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
    end
  end

  assign z_c = (res_c == '0);
  assign n_c = res_c[W-1];

`ifdef ALU_MUL_EN
  logic [2*W-1:0]   mcand_q, acc_q, acc_nx;
  logic [W-1:0]     mplier_q, prod_lo;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_last, prod_v;

  assign is_mul      = (op4 == OP_MUL) && !undef_op;
  assign start_state = is_mul ? S_MUL : S_DONE;
  assign acc_nx      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_last    = (state_q == S_MUL) && (cnt_q == CNT_W'(W - 1));
  assign prod_lo     = acc_nx[W-1:0];
  assign prod_v      = |acc_nx[2*W-1:W];

  // Shift-add multiplier: one multiplier bit per cycle, LSB first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{W{1'b0}}, alu_in_a};
      mplier_q <= alu_in_b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nx;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign is_mul      = 1'b0;
  assign start_state = S_DONE;
`endif

  // Handshake and next-state: a held result may be replaced in the same cycle it is taken
  always_comb begin
    state_d      = state_q;
    alu_in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && alu_out_ready);
    accept       = alu_in_valid && alu_in_ready;
    case (state_q)
      S_IDLE: if (accept) state_d = start_state;
      S_DONE: begin
        if (accept)             state_d = start_state;
        else if (alu_out_ready) state_d = S_IDLE;
      end
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_last) state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Result/flag next value: load on a single-cycle accept or on the final MUL step, else hold
  always_comb begin
    out_d    = out_q;
    status_d = status_q;
    if (accept && !is_mul) begin
      out_d    = res_c;
      status_d = {v_c, c_c, n_c, z_c};
    end
`ifdef ALU_MUL_EN
    else if (mul_last) begin
      out_d    = prod_lo;
      status_d = {prod_v, 1'b0, prod_lo[W-1], (prod_lo == '0)};
    end
`endif
  end

  // State, result and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      status_q <= status_d;
    end
  end

  assign alu_out_valid = (state_q == S_DONE);
  assign alu_out       = out_q;
  assign alu_status    = status_q;

endmodule

// File: tb/tb_ceyloniac_alu_mc.sv
// Bench for ceyloniac_alu_mc (32-bit data, 4-bit opcode): directed vectors,
// expected responses queued at issue time and checked by a separate monitor.
module tb_ceyloniac_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_in_valid;
  logic        alu_in_ready;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [3:0]  alu_sel;
  logic        alu_out_valid;
  logic        alu_out_ready;
  logic [31:0] alu_out;
  logic [3:0]  alu_status;

  ceyloniac_alu_mc #(
    .ALU_DATA_WIDTH(32),
    .ALU_OP_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_in_valid (alu_in_valid),
    .alu_in_ready (alu_in_ready),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_sel      (alu_sel),
    .alu_out_valid(alu_out_valid),
    .alu_out_ready(alu_out_ready),
    .alu_out      (alu_out),
    .alu_status   (alu_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] out;
    logic [3:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

`ifdef ALU_MUL_EN
  localparam int          MUL_LAT = 32;
  localparam logic [31:0] M76_OUT = 32'd42;
  localparam logic [3:0]  M76_ST  = 4'h0;
`else
  localparam int          MUL_LAT = 0;
  localparam logic [31:0] M76_OUT = 32'd0;
  localparam logic [3:0]  M76_ST  = 4'h9;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Present one op and hold it until accepted (bounded wait)
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    int n;
    alu_in_a     = a;
    alu_in_b     = b;
    alu_sel      = sel;
    alu_in_valid = 1'b1;
    n = 0;
    while (!alu_in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: alu_in_ready stayed low for %0d cycles, want high", n);
    end
    @(posedge clk); #1;
    alu_in_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                       input logic [31:0] eo, input logic [3:0] es);
    exp_q.push_back({eo, es});
    drive(a, b, sel);
  endtask

  // Monitor: every result taken by the consumer is compared with the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!reset && alu_out_valid && alu_out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got out=%h status=%h, want no result", alu_out, alu_status);
      end else begin
        e = exp_q.pop_front();
        chk("result", alu_out, e.out);
        chk("status", 32'(alu_status), 32'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    reset         = 1'b1;
    alu_in_valid  = 1'b0;
    alu_in_a      = '0;
    alu_in_b      = '0;
    alu_sel       = '0;
    alu_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(alu_out_valid), 32'd0);
    chk("rst_out", alu_out, 32'd0);
    chk("rst_status", 32'(alu_status), 32'd0);
    chk("rst_ready", 32'(alu_in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Arithmetic and flag boundaries
    issue(32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'hA);
    chk("add_latency", 32'(alu_out_valid), 32'd1);
    issue(32'h0, 32'h1, 4'b0001, 32'hFFFFFFFF, 4'h6);
    issue(32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 4'h5);
    issue(32'h80000000, 32'h1, 4'b0001, 32'h7FFFFFFF, 4'h8);
    issue(32'hFFFFFFFF, 32'h0, 4'b0011, 32'h0, 4'h5);
    issue(32'h0, 32'h0, 4'b0100, 32'hFFFFFFFF, 4'h6);
    issue(32'h80000000, 32'h0, 4'b0100, 32'h7FFFFFFF, 4'h8);
    // Shifts, logic, extract, pass
    issue(32'h80000000, 32'h4, 4'b1101, 32'hF8000000, 4'h2);
    issue(32'h1, 32'd31, 4'b0110, 32'h80000000, 4'h2);
    issue(32'h80000000, 32'd31, 4'b0111, 32'h1, 4'h0);
    issue(32'hF0, 32'h24, 4'b0111, 32'hF, 4'h0);
    issue(32'hF0F0F0F0, 32'h0FF00FF0, 4'b1000, 32'h00F000F0, 4'h0);
    issue(32'hF0000000, 32'h0000000F, 4'b1001, 32'hF000000F, 4'h2);
    issue(32'h0, 32'h0, 4'b1011, 32'hFFFFFFFF, 4'h2);
    issue(32'h0, 32'h0, 4'b1100, 32'h1, 4'h0);
    issue(32'h5, 32'h0, 4'b1100, 32'h0, 4'h1);
    issue(32'hDEADBEEF, 32'h108, 4'b1110, 32'h000000BE, 4'h0);
    issue(32'hDEADBEEF, 32'h4, 4'b1110, 32'h0DEADBEE, 4'h0);
    issue(32'hDEADBEEF, 32'h11C, 4'b1110, 32'h0000000D, 4'h0);
    issue(32'h0, 32'hFFFF, 4'b0101, 32'h0, 4'h1);
    issue(32'h12345678, 32'h0, 4'b1111, 32'h12345678, 4'h0);

    // Multiply (or its unsupported form) and its latency
    issue(32'h10000, 32'h10000, 4'b0010, 32'h0, 4'h9);
    n = 0;
    while (!alu_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'(MUL_LAT));
    @(posedge clk); #1;
    issue(32'd7, 32'd6, 4'b0010, M76_OUT, M76_ST);
    n = 0;
    while (!alu_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul76_latency", 32'(n), 32'(MUL_LAT));
    @(posedge clk); #1;

    // Streaming: eight back-to-back ops, one per cycle
    c0 = cyc;
    issue(32'h1, 32'h2, 4'b0000, 32'h3, 4'h0);
    issue(32'hFF, 32'h0F, 4'b1010, 32'hF0, 4'h0);
    issue(32'h10, 32'h20, 4'b0000, 32'h30, 4'h0);
    issue(32'hAAAAAAAA, 32'h55555555, 4'b1010, 32'hFFFFFFFF, 4'h2);
    issue(32'h80000000, 32'h80000000, 4'b0000, 32'h0, 4'hD);
    issue(32'h5, 32'h5, 4'b1010, 32'h0, 4'h1);
    issue(32'h100, 32'hFF, 4'b0000, 32'h1FF, 4'h0);
    issue(32'h0, 32'h80000000, 4'b1010, 32'h80000000, 4'h2);
    chk("stream_cycles", 32'(cyc - c0), 32'd8);
    @(posedge clk); #1;

    // Backpressure: result and flags held, new op waits, then 1-cycle handoff
    alu_out_ready = 1'b0;
    issue(32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'hA);
    alu_in_a     = 32'hF0F0F0F0;
    alu_in_b     = 32'hFFFFFFFF;
    alu_sel      = 4'b1010;
    alu_in_valid = 1'b1;
    exp_q.push_back({32'h0F0F0F0F, 4'h0});
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(alu_out_valid), 32'd1);
      chk("bp_ready", 32'(alu_in_ready), 32'd0);
      chk("bp_out", alu_out, 32'h80000000);
      chk("bp_status", 32'(alu_status), 32'hA);
      @(posedge clk); #1;
    end
    alu_out_ready = 1'b1;
    @(posedge clk); #1;
    alu_in_valid = 1'b0;
    chk("handoff_out", alu_out, 32'h0F0F0F0F);
    chk("handoff_valid", 32'(alu_out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a result is in flight or held
    alu_out_ready = 1'b0;
    drive(32'd7, 32'd6, 4'b0010);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(alu_out_valid), 32'd0);
    chk("midrst_out", alu_out, 32'd0);
    chk("midrst_status", 32'(alu_status), 32'd0);
    chk("midrst_ready", 32'(alu_in_ready), 32'd1);
    @(posedge clk); #1;
    reset         = 1'b0;
    alu_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (alu_out_valid) begin
        n_vec++;
        n_miss++;
        $display("FAIL stale_after_reset: alu_out_valid=1 at cycle %0d after reset, want 0", i);
        break;
      end
    end
    chk("post_rst_valid", 32'(alu_out_valid), 32'd0);

    // Drain anything still expected
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
